// File: rtl/regbank_pkg.sv
// Shared constants and the address decoder used by the register-bank write scheduler.
// Address 0 is the hard-wired zero register, so it decodes to no enable at all.
package regbank_pkg;

    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = 5;
    localparam int DW           = 32;
    localparam logic [AW_DEFAULT-1:0] REG_ZERO = '0;

    function automatic logic [NREG_DEFAULT-1:0] onehot_decode(input logic [AW_DEFAULT-1:0] addr);
        logic [NREG_DEFAULT-1:0] v;
        v = '0;
        if (addr != REG_ZERO) begin
            v[addr] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps modulo NREQ.
// The first active request wins; nothing is granted while i_enable is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    input  logic            i_enable,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_grant_idx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (i_enable && !w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = PW'(w_idx);
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_write_scheduler.sv
// Shares the single write port of the register bank among NREQ requesters and decodes
// the read port, flagging same-cycle read-after-write so the reader can bypass the bus.
module regbank_write_scheduler #(
    parameter int NREQ = 4,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREG-1:0]    wr_en,
    output logic [DW-1:0]      wr_data,
    output logic [PW-1:0]      grant_id,
    input  logic [AW-1:0]      rd_addr,
    output logic [NREG-1:0]    rd_oe,
    output logic               rd_zero,
    output logic               rd_bypass,
    output logic [DW-1:0]      rd_bypass_data
);
    import regbank_pkg::*;

    logic [PW-1:0]   r_ptr;
    logic [NREG-1:0] r_wr_en;
    logic [DW-1:0]   r_wr_data;
    logic [PW-1:0]   r_grant_id;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_grant_idx;
    logic            w_accept;
    logic [PW-1:0]   w_ptr_next;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .i_enable    (!hold && !clr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // A grant is only ever issued to a valid requester, so any grant is a handshake.
    assign w_accept   = |w_grant;
    assign w_ptr_next = (w_grant_idx == PW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_ptr      <= '0;
            r_wr_en    <= '0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
        end else if (w_accept) begin
            r_ptr      <= w_ptr_next;
            r_wr_en    <= NREG'(onehot_decode(AW_DEFAULT'(w_sel_addr)));
            r_wr_data  <= w_sel_data;
            r_grant_id <= w_grant_idx;
        end else begin
            r_wr_en    <= '0;
        end
    end

    assign req_ready = w_grant;
    assign wr_en     = r_wr_en;
    assign wr_data   = r_wr_data;
    assign grant_id  = r_grant_id;

    // Register 0 has no driver on the read bus; the consumer substitutes zero.
    assign rd_oe          = NREG'(onehot_decode(AW_DEFAULT'(rd_addr)));
    assign rd_zero        = (rd_addr == '0);
    assign rd_bypass      = (r_wr_en != '0) && r_wr_en[rd_addr];
    assign rd_bypass_data = r_wr_data;

endmodule
